rolha_supply_scheduler: RTL and testbench

- Sequences cork (rolha) supply for the sealing station: holds the stock counter and the line-buffer counter.
- Decides when to request a dispenser refill and moves corks stock→line one per cycle after the dispenser acknowledges.
- Arbitrates simultaneous consume (seal done), transfer and operator restock events. Raises the low-stock alarm.
- Sits between the sealing FSM (consumer), the dispenser actuator and the decimal displays.

---
 rtl/rolha_pkg.sv | 15 +
 rtl/sat_updown_counter.sv | 41 ++++
 rtl/rolha_supply_scheduler.sv | 161 ++++++++++++++++
 tb/tb_rolha_supply_scheduler.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rolha_pkg.sv
// Shared definitions for the cork supply scheduler: FSM encoding and default sizes.
package rolha_pkg;

  localparam int DEF_CNT_W     = 8;
  localparam int DEF_STOCK_MAX = 99;
  localparam int DEF_LINE_MAX  = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/sat_updown_counter.sv
// Saturating up/down counter: +STEP (clamped at MAX), -1 (held at 0), load has priority.
// Exposes the next value so callers can register flags derived from the updated count.
module sat_updown_counter #(
  parameter int W    = 8,
  parameter int MAX  = 255,
  parameter int STEP = 1
) (
  input  logic         clk,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic [W-1:0] cnt_d_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W:0]   sum;

  always_comb begin
    sum   = {1'b0, cnt_q};
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (inc_i) begin
      // simultaneous inc and dec nets to STEP-1 before clamping
      sum   = {1'b0, cnt_q} + (W+1)'(STEP) - (W+1)'(dec_i);
      cnt_d = (sum > (W+1)'(MAX)) ? W'(MAX) : sum[W-1:0];
    end else if (dec_i && cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign cnt_o   = cnt_q;
  assign cnt_d_o = cnt_d;

endmodule

// File: rtl/rolha_supply_scheduler.sv
// Cork supply scheduler: refill request/transfer FSM over stock and line-buffer counters.
// Defining ROLHA_ACK_WATCHDOG_EN adds a dispenser-ack timeout with a sticky fault.
//
//   state | meaning
//   IDLE  | wait for low line (or operator request) with stock available
//   REQ   | disp_req high, waiting for dispenser ack
//   XFER  | move one cork stock->line per cycle until batch exhausted
//   DONE  | one-cycle refill_done, then back to IDLE
module rolha_supply_scheduler #(
  parameter int CNT_W      = rolha_pkg::DEF_CNT_W,
  parameter int STOCK_INIT = 20,
  parameter int STOCK_MAX  = rolha_pkg::DEF_STOCK_MAX,
  parameter int STOCK_ADD  = 15,
  parameter int LINE_MAX   = rolha_pkg::DEF_LINE_MAX,
  parameter int REFILL_LVL = 5,
  parameter int BATCH      = 10,
  parameter int ALARM_LVL  = 5
`ifdef ROLHA_ACK_WATCHDOG_EN
  , parameter int ACK_TIMEOUT = 8
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             consume,
  input  logic             man_req,
  input  logic             add_stock,
  input  logic             disp_ack,
  output logic             disp_req,
  output logic             disp_pulse,
  output logic [CNT_W-1:0] line_cnt,
  output logic [CNT_W-1:0] stock_cnt,
  output logic             cork_avail,
  output logic             stock_low,
  output logic             underrun,
  output logic             refill_done,
  output logic             fault
);
  import rolha_pkg::*;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] xfer_q, xfer_d, xfer_load, room;
  logic [CNT_W-1:0] line_q, line_d, stock_q, stock_d;
  logic             xfer_go, refill_want, fault_int;
  logic             disp_req_q, disp_pulse_q, underrun_q, refill_done_q;
  logic             cork_avail_q, stock_low_q;

`ifdef ROLHA_ACK_WATCHDOG_EN
  logic             fault_q, fault_d;
  logic [CNT_W-1:0] wd_q, wd_d;
  assign fault_int = fault_q;
`else
  assign fault_int = 1'b0;
`endif

  // batch = min(BATCH, stock, free line slots)
  always_comb begin
    room      = CNT_W'(LINE_MAX) - line_q;
    xfer_load = CNT_W'(BATCH);
    if (stock_q < xfer_load) xfer_load = stock_q;
    if (room < xfer_load)    xfer_load = room;
  end

  assign refill_want = (line_q < CNT_W'(REFILL_LVL) || man_req) &&
                       (line_q < CNT_W'(LINE_MAX)) && (stock_q != '0) && !fault_int;

  always_comb begin
    state_d = state_q;
    xfer_d  = xfer_q;
    xfer_go = 1'b0;
`ifdef ROLHA_ACK_WATCHDOG_EN
    fault_d = fault_q;
    wd_d    = (state_q == REQ && wd_q != '0) ? wd_q - CNT_W'(1) : CNT_W'(ACK_TIMEOUT - 1);
`endif
    case (state_q)
      IDLE: if (refill_want) state_d = REQ;
      REQ: begin
        if (disp_ack) begin
          xfer_d  = xfer_load;
          state_d = XFER;
        end
`ifdef ROLHA_ACK_WATCHDOG_EN
        else if (wd_q == '0) begin
          state_d = IDLE;
          fault_d = 1'b1;
        end
`endif
      end
      XFER: begin
        if (xfer_q != '0 && stock_q != '0) begin
          xfer_go = 1'b1;
          xfer_d  = xfer_q - CNT_W'(1);
          if (xfer_q == CNT_W'(1) || (stock_q == CNT_W'(1) && !add_stock)) state_d = DONE;
        end else begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  sat_updown_counter #(.W(CNT_W), .MAX(LINE_MAX), .STEP(1)) u_line (
    .clk        (clk),
    .load_i     (!reset),
    .load_val_i ('0),
    .inc_i      (xfer_go),
    .dec_i      (consume),
    .cnt_o      (line_q),
    .cnt_d_o    (line_d)
  );

  sat_updown_counter #(.W(CNT_W), .MAX(STOCK_MAX), .STEP(STOCK_ADD)) u_stock (
    .clk        (clk),
    .load_i     (!reset),
    .load_val_i (CNT_W'(STOCK_INIT)),
    .inc_i      (add_stock),
    .dec_i      (xfer_go),
    .cnt_o      (stock_q),
    .cnt_d_o    (stock_d)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      xfer_q        <= '0;
      disp_req_q    <= 1'b0;
      disp_pulse_q  <= 1'b0;
      underrun_q    <= 1'b0;
      refill_done_q <= 1'b0;
`ifdef ROLHA_ACK_WATCHDOG_EN
      fault_q       <= 1'b0;
      wd_q          <= CNT_W'(ACK_TIMEOUT - 1);
`endif
    end else begin
      state_q       <= state_d;
      xfer_q        <= xfer_d;
      disp_req_q    <= (state_d == REQ);
      disp_pulse_q  <= xfer_go;
      underrun_q    <= consume && (line_q == '0);
      refill_done_q <= (state_d == DONE);
`ifdef ROLHA_ACK_WATCHDOG_EN
      fault_q       <= fault_d;
      wd_q          <= wd_d;
`endif
    end
    // flags follow the counters' next value, including the reset load
    stock_low_q  <= (stock_d < CNT_W'(ALARM_LVL));
    cork_avail_q <= (line_d != '0);
  end

  assign disp_req    = disp_req_q;
  assign disp_pulse  = disp_pulse_q;
  assign line_cnt    = line_q;
  assign stock_cnt   = stock_q;
  assign cork_avail  = cork_avail_q;
  assign stock_low   = stock_low_q;
  assign underrun    = underrun_q;
  assign refill_done = refill_done_q;
  assign fault       = fault_int;

endmodule

// File: tb/tb_rolha_supply_scheduler.sv
// Scoreboard bench for rolha_supply_scheduler: stimulus queues expected snapshots and
// events; a negedge monitor pops and compares them against the DUT outputs.
module tb_rolha_supply_scheduler;

  logic       clk = 1'b0;
  logic       reset, consume, man_req, add_stock, disp_ack;
  logic       disp_req, disp_pulse, cork_avail, stock_low, underrun, refill_done, fault;
  logic [7:0] line_cnt, stock_cnt;

  int vectors = 0;
  int fails   = 0;
  int pcount  = 0;

  typedef struct {
    string name;
    int    line;
    int    stock;
    bit    req;
    bit    low;
    bit    avail;
    bit    pulse;
    bit    flt;
  } snap_t;

  typedef struct {
    int line;
    int stock;
    int pulses;
  } done_t;

  snap_t q_snap[$];
  done_t q_done[$];
  int    q_under[$];

  always #5 clk = ~clk;

  rolha_supply_scheduler dut (
    .clk         (clk),
    .reset       (reset),
    .consume     (consume),
    .man_req     (man_req),
    .add_stock   (add_stock),
    .disp_ack    (disp_ack),
    .disp_req    (disp_req),
    .disp_pulse  (disp_pulse),
    .line_cnt    (line_cnt),
    .stock_cnt   (stock_cnt),
    .cork_avail  (cork_avail),
    .stock_low   (stock_low),
    .underrun    (underrun),
    .refill_done (refill_done),
    .fault       (fault)
  );

  task automatic chk(input string n, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", n, act, exp);
    end
  endtask

  // Monitor: compares queued expectations whenever the DUT presents an event.
  always @(negedge clk) begin
    snap_t s;
    done_t d;
    int    u;
    if (!reset) begin
      pcount = 0;
    end else begin
      if (disp_pulse) pcount++;
      if (refill_done) begin
        if (q_done.size() == 0) begin
          vectors++;
          fails++;
          $display("FAIL unexpected_refill_done: got 1, want 0");
        end else begin
          d = q_done.pop_front();
          chk("done_line", int'(line_cnt), d.line);
          chk("done_stock", int'(stock_cnt), d.stock);
          chk("done_pulses", pcount, d.pulses);
        end
        pcount = 0;
      end
      if (underrun) begin
        if (q_under.size() == 0) begin
          vectors++;
          fails++;
          $display("FAIL unexpected_underrun: got 1, want 0");
        end else begin
          u = q_under.pop_front();
          chk("underrun_line", int'(line_cnt), u);
        end
      end
    end
    while (q_snap.size() != 0) begin
      s = q_snap.pop_front();
      chk({s.name, "_line"},  int'(line_cnt),   s.line);
      chk({s.name, "_stock"}, int'(stock_cnt),  s.stock);
      chk({s.name, "_req"},   int'(disp_req),   int'(s.req));
      chk({s.name, "_low"},   int'(stock_low),  int'(s.low));
      chk({s.name, "_avail"}, int'(cork_avail), int'(s.avail));
      chk({s.name, "_pulse"}, int'(disp_pulse), int'(s.pulse));
      chk({s.name, "_fault"}, int'(fault),      int'(s.flt));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic snap(input string n, input int l, input int s, input bit r,
                      input bit lo, input bit p, input bit f);
    snap_t e;
    e.name  = n;
    e.line  = l;
    e.stock = s;
    e.req   = r;
    e.low   = lo;
    e.avail = (l != 0);
    e.pulse = p;
    e.flt   = f;
    q_snap.push_back(e);
  endtask

  task automatic expect_done(input int l, input int s, input int p);
    done_t e;
    e.line   = l;
    e.stock  = s;
    e.pulses = p;
    q_done.push_back(e);
  endtask

  task automatic wait_done(input string n);
    int k;
    k = 0;
    while (refill_done !== 1'b1 && k < 40) begin
      tick();
      k++;
    end
    if (refill_done !== 1'b1) begin
      vectors++;
      fails++;
      $display("FAIL %s_timeout: got no refill_done, want one within 40 cycles", n);
    end
  endtask

  initial begin
    reset = 1'b0; consume = 1'b0; man_req = 1'b0; add_stock = 1'b0; disp_ack = 1'b0;
    ticks(2);
    snap("rst", 0, 20, 0, 0, 0, 0);
    reset = 1'b1;

    // Power-up: empty line triggers an auto refill of 10
    tick();
    snap("req_rise", 0, 20, 1, 0, 0, 0);
    disp_ack = 1'b1; tick(); disp_ack = 1'b0;
    expect_done(10, 10, 10);
    wait_done("batch1"); tick();
    snap("batch1", 10, 10, 0, 0, 0, 0);

    // Consume down to 4, second batch drains stock to 0
    consume = 1'b1; ticks(5); consume = 1'b0;
    snap("cons5", 5, 10, 0, 0, 0, 0);
    consume = 1'b1; tick(); consume = 1'b0;
    snap("cons_to4", 4, 10, 0, 0, 0, 0);
    tick();
    snap("req_low", 4, 10, 1, 0, 0, 0);
    disp_ack = 1'b1; tick(); disp_ack = 1'b0;
    expect_done(14, 0, 10);
    wait_done("batch2"); tick();
    snap("batch2", 14, 0, 0, 1, 0, 0);

    // Empty stock: man_req ignored
    man_req = 1'b1; ticks(3); man_req = 1'b0;
    snap("empty_ignore", 14, 0, 0, 1, 0, 0);
    add_stock = 1'b1; tick(); add_stock = 1'b0;
    snap("restock", 14, 15, 0, 0, 0, 0);

    // Manual refill limited by one free slot
    man_req = 1'b1; tick(); man_req = 1'b0;
    snap("man_req", 14, 15, 1, 0, 0, 0);
    disp_ack = 1'b1; tick(); disp_ack = 1'b0;
    expect_done(15, 14, 1);
    wait_done("room1"); tick();
    snap("room1", 15, 14, 0, 0, 0, 0);
    man_req = 1'b1; ticks(2); man_req = 1'b0;
    snap("line_full", 15, 14, 0, 0, 0, 0);

    // Consume coinciding with a transfer cycle
    consume = 1'b1; ticks(11); consume = 1'b0;
    snap("cons11", 4, 14, 0, 0, 0, 0);
    tick();
    snap("req3", 4, 14, 1, 0, 0, 0);
    disp_ack = 1'b1; tick(); disp_ack = 1'b0;
    expect_done(13, 4, 10);
    ticks(2);
    consume = 1'b1; tick(); consume = 1'b0;
    wait_done("batch3"); tick();
    snap("batch3", 13, 4, 0, 1, 0, 0);

    // Restock and saturation at 99
    add_stock = 1'b1; tick(); add_stock = 1'b0;
    snap("add_low", 13, 19, 0, 0, 0, 0);
    add_stock = 1'b1; ticks(5); add_stock = 1'b0;
    snap("add5", 13, 94, 0, 0, 0, 0);
    add_stock = 1'b1; tick(); add_stock = 1'b0;
    snap("sat", 13, 99, 0, 0, 0, 0);

    // Drain line with no ack, then underrun
    consume = 1'b1; ticks(13); consume = 1'b0;
    snap("drain", 0, 99, 1, 0, 0, 0);
    q_under.push_back(0);
    consume = 1'b1; tick(); consume = 1'b0;
    snap("underrun", 0, 99, 1, 0, 0, 0);
    ticks(20);
`ifdef ROLHA_ACK_WATCHDOG_EN
    snap("wd_fault", 0, 99, 0, 0, 0, 1);
`else
    snap("no_wd", 0, 99, 1, 0, 0, 0);
`endif

    // Reset while idle/waiting, then reset mid-transfer
    reset = 1'b0; tick();
    snap("rst2", 0, 20, 0, 0, 0, 0);
    @(negedge clk); reset = 1'b1;
    tick();
    snap("req_again", 0, 20, 1, 0, 0, 0);
    disp_ack = 1'b1; tick(); disp_ack = 1'b0;
    ticks(3);
    snap("mid_xfer", 3, 17, 0, 0, 1, 0);
    reset = 1'b0; tick();
    snap("rst_mid", 0, 20, 0, 0, 0, 0);
    @(negedge clk); reset = 1'b1;
    tick();
    snap("req_post", 0, 20, 1, 0, 0, 0);

    ticks(2);
    chk("done_queue_left", q_done.size(), 0);
    chk("under_queue_left", q_under.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
